// File: rtl/dac_spi_tx_pkg.sv
// Shared definitions for the DAC serial output stage: FSM encoding, default
// sample width and a constant-foldable clog2.
package dac_spi_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_GAP   = 2'b11
    } state_t;

    localparam int W_DEF = 16;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO; dout is registered and becomes valid the cycle after
// a pop. A push while full is only taken when a pop frees the slot that cycle.
module sync_fifo
    import dac_spi_tx_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [W-1:0]          din,
    output logic [W-1:0]          dout,
    output logic                  full,
    output logic                  empty,
    output logic [clog2(DEPTH):0] level
);

    localparam int AW = clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign full  = (level == (AW + 1)'(DEPTH));
    assign empty = (level == '0);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            dout   <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                dout   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/dac_spi_tx.sv
// Buffers modulator samples and shifts each one MSB-first to a 3-wire DAC
// link (mode 0, chip-select framed), flagging samples lost to a full FIFO.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | link quiet, waiting for a buffered sample
//   ST_LOAD  | head word (popped on entry) converted and presented, CS low
//   ST_SHIFT | SCLK running, one bit per full SCLK period
//   ST_GAP   | CS high between frames, GAP*DIV cycles
module dac_spi_tx
    import dac_spi_tx_pkg::*;
#(
    parameter int W          = W_DEF,
    parameter int DEPTH      = 4,
    parameter int DIV        = 2,
    parameter int GAP        = 2,
    parameter bit OFFSET_BIN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [W-1:0]          i_data,
    input  logic                  val_in,
    output logic                  o_sclk,
    output logic                  o_sdata,
    output logic                  o_cs_n,
    output logic                  o_busy,
    output logic                  o_ovf,
    output logic [clog2(DEPTH):0] o_level
);

    localparam int DW = (DIV > 1) ? clog2(DIV) : 1;
    localparam int BW = (W > 1) ? clog2(W) : 1;
    localparam int GW = (GAP * DIV > 1) ? clog2(GAP * DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP * DIV - 1);

    state_t         state;
    state_t         state_nxt;
    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [W-1:0]   fifo_dout;
    logic [W-1:0]   load_word;
    logic [W-1:0]   shift_reg;
    logic [DW-1:0]  div_cnt;
    logic [BW-1:0]  bit_cnt;
    logic [GW-1:0]  gap_cnt;
    logic           sclk_int;
    logic           div_wrap;
    logic           gap_done;
    logic           last_fall;
    logic           cs_n_c;
    logic           sclk_c;
    logic           sdata_c;
    logic           busy_c;

    sync_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (val_in),
        .pop   (fifo_pop),
        .din   (i_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (o_level)
    );

    // Offset binary differs from two's complement only in the sign bit.
    assign load_word = OFFSET_BIN ? {~fifo_dout[W-1], fifo_dout[W-2:0]} : fifo_dout;

    assign div_wrap  = (div_cnt == DIV_LAST);
    assign gap_done  = (gap_cnt == '0);
    assign last_fall = (state == ST_SHIFT) && div_wrap && sclk_int && (bit_cnt == BIT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The pop is issued on the edge that enters LOAD so the registered FIFO
    // output is already valid while LOAD presents the MSB.
    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        cs_n_c    = 1'b1;
        sclk_c    = 1'b0;
        sdata_c   = 1'b0;
        busy_c    = 1'b1;
        case (state)
            ST_IDLE: begin
                busy_c = 1'b0;
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cs_n_c    = 1'b0;
                sdata_c   = load_word[W-1];
                state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                cs_n_c  = 1'b0;
                sclk_c  = sclk_int;
                sdata_c = shift_reg[W-1];
                if (last_fall) begin
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_done) begin
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        state_nxt = ST_LOAD;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg <= '0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            sclk_int  <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    shift_reg <= load_word;
                    div_cnt   <= '0;
                    bit_cnt   <= '0;
                    sclk_int  <= 1'b0;
                end
                ST_SHIFT: begin
                    if (div_wrap) begin
                        div_cnt  <= '0;
                        sclk_int <= ~sclk_int;
                        if (sclk_int) begin
                            shift_reg <= {shift_reg[W-2:0], 1'b0};
                            bit_cnt   <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                    if (last_fall) begin
                        gap_cnt <= GAP_LOAD;
                    end
                end
                ST_GAP: begin
                    if (!gap_done) begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                default: begin
                    div_cnt  <= '0;
                    sclk_int <= 1'b0;
                end
            endcase
        end
    end

    // Registered pins keep the link glitch-free; every pin shares the same
    // one-cycle delay, so intra-frame timing is preserved.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_cs_n  <= 1'b1;
            o_sclk  <= 1'b0;
            o_sdata <= 1'b0;
            o_busy  <= 1'b0;
            o_ovf   <= 1'b0;
        end else begin
            o_cs_n  <= cs_n_c;
            o_sclk  <= sclk_c;
            o_sdata <= sdata_c;
            o_busy  <= busy_c;
            o_ovf   <= val_in && fifo_full && !fifo_pop;
        end
    end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Self-checking bench for dac_spi_tx: a negedge monitor decodes frames and
// compares them with a scoreboard filled as samples are driven.
module tb_dac_spi_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] i_data = '0;
    logic        val_in = 1'b0;
    logic        o_sclk, o_sdata, o_cs_n, o_busy, o_ovf;
    logic [2:0]  o_level;

    logic [15:0] raw_data = '0;
    logic        raw_val = 1'b0;
    logic        r_sclk, r_sdata, r_cs_n, r_busy, r_ovf;
    logic [2:0]  r_level;

    int checks = 0;
    int errors = 0;

    logic [15:0] sb [$];
    int          frames_done = 0;
    int          last_gap = 0;

    logic        prev_cs = 1'b1;
    logic        prev_sclk = 1'b0;
    logic        in_frame = 1'b0;
    logic [15:0] cap = '0;
    logic [15:0] exp_word = '0;
    int          nbits = 0;
    int          low_cnt = 0;
    int          high_cnt = 0;

    dac_spi_tx #(.W(16), .DEPTH(4), .DIV(2), .GAP(2), .OFFSET_BIN(1'b1)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_data  (i_data),
        .val_in  (val_in),
        .o_sclk  (o_sclk),
        .o_sdata (o_sdata),
        .o_cs_n  (o_cs_n),
        .o_busy  (o_busy),
        .o_ovf   (o_ovf),
        .o_level (o_level)
    );

    dac_spi_tx #(.W(16), .DEPTH(4), .DIV(2), .GAP(2), .OFFSET_BIN(1'b0)) dut_raw (
        .clk     (clk),
        .rst     (rst),
        .i_data  (raw_data),
        .val_in  (raw_val),
        .o_sclk  (r_sclk),
        .o_sdata (r_sdata),
        .o_cs_n  (r_cs_n),
        .o_busy  (r_busy),
        .o_ovf   (r_ovf),
        .o_level (r_level)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_dac(input logic [15:0] d);
        return {~d[15], d[14:0]};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            in_frame  = 1'b0;
            prev_cs   = 1'b1;
            prev_sclk = 1'b0;
            high_cnt  = 0;
        end else begin
            if (prev_cs && !o_cs_n) begin
                in_frame = 1'b1;
                cap      = '0;
                nbits    = 0;
                low_cnt  = 0;
                last_gap = high_cnt;
            end
            if (!o_cs_n) begin
                low_cnt++;
                high_cnt = 0;
                if (o_sclk && !prev_sclk) begin
                    cap = {cap[14:0], o_sdata};
                    nbits++;
                end
            end else begin
                high_cnt++;
            end
            if (!prev_cs && o_cs_n && in_frame) begin
                in_frame = 1'b0;
                frames_done++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_frame: got %h with no sample pending", cap);
                end else begin
                    exp_word = sb.pop_front();
                    if (cap !== exp_word) begin
                        errors++;
                        $display("FAIL frame_word: got %h, expected %h", cap, exp_word);
                    end
                    checks++;
                    if (nbits !== 16) begin
                        errors++;
                        $display("FAIL sclk_pulses: got %0d, expected 16", nbits);
                    end
                    checks++;
                    if (low_cnt !== 65) begin
                        errors++;
                        $display("FAIL cs_low_cycles: got %0d, expected 65", low_cnt);
                    end
                end
            end
            prev_cs   = o_cs_n;
            prev_sclk = o_sclk;
        end
    end

    task automatic send(input logic [15:0] d);
        @(posedge clk);
        #1 i_data = d;
        val_in = 1'b1;
        sb.push_back(to_dac(d));
        @(posedge clk);
        #1 val_in = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frames_done < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (frames_done < target) begin
            errors++;
            $display("FAIL frame_timeout: got %0d frames, expected %0d", frames_done, target);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++; if (o_sclk !== 1'b0)  begin errors++; $display("FAIL rst_sclk: got %b, expected 0", o_sclk); end
        checks++; if (o_sdata !== 1'b0) begin errors++; $display("FAIL rst_sdata: got %b, expected 0", o_sdata); end
        checks++; if (o_cs_n !== 1'b1)  begin errors++; $display("FAIL rst_cs_n: got %b, expected 1", o_cs_n); end
        checks++; if (o_busy !== 1'b0)  begin errors++; $display("FAIL rst_busy: got %b, expected 0", o_busy); end
        checks++; if (o_ovf !== 1'b0)   begin errors++; $display("FAIL rst_ovf: got %b, expected 0", o_ovf); end
        checks++; if (o_level !== 3'd0) begin errors++; $display("FAIL rst_level: got %0d, expected 0", o_level); end
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_single();
        int base = frames_done;
        send(16'h0000);
        checks++; if (o_level !== 3'd1) begin errors++; $display("FAIL single_level: got %0d, expected 1", o_level); end
        @(posedge clk); #1;
        checks++; if (o_cs_n !== 1'b1) begin errors++; $display("FAIL single_cs_early: got %b, expected 1", o_cs_n); end
        @(posedge clk); #1;
        checks++; if (o_cs_n !== 1'b0)  begin errors++; $display("FAIL single_cs_fall: got %b, expected 0", o_cs_n); end
        checks++; if (o_sdata !== 1'b1) begin errors++; $display("FAIL single_msb: got %b, expected 1", o_sdata); end
        checks++; if (o_busy !== 1'b1)  begin errors++; $display("FAIL single_busy: got %b, expected 1", o_busy); end
        wait_frames(base + 1, 200);
    endtask

    task automatic test_back_to_back();
        int base = frames_done;
        send(16'h7FFF);
        send(16'h8000);
        wait_frames(base + 2, 400);
        checks++;
        if (last_gap !== 4) begin
            errors++;
            $display("FAIL frame_gap: got %0d cs-high cycles, expected 4", last_gap);
        end
    endtask

    task automatic test_raw();
        logic        ps = 1'b0;
        logic        started = 1'b0;
        logic        done = 1'b0;
        logic [15:0] w = '0;
        int          pulses = 0;
        @(posedge clk);
        #1 raw_data = 16'hA5C3;
        raw_val = 1'b1;
        @(posedge clk);
        #1 raw_val = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (!r_cs_n) begin
                started = 1'b1;
                if (r_sclk && !ps) begin
                    w = {w[14:0], r_sdata};
                    pulses++;
                end
            end else if (started) begin
                done = 1'b1;
            end
            ps = r_sclk;
        end
        checks++; if (!done) begin errors++; $display("FAIL raw_timeout: frame end %b, expected 1", done); end
        checks++; if (w !== 16'hA5C3) begin errors++; $display("FAIL raw_word: got %h, expected a5c3", w); end
        checks++; if (pulses !== 16) begin errors++; $display("FAIL raw_pulses: got %0d, expected 16", pulses); end
    endtask

    task automatic test_burst();
        logic [15:0] tab [6] = '{16'h0123, 16'hFEDC, 16'h4000, 16'hC000, 16'h7FFE, 16'hDEAD};
        int base;
        int ovf_cnt = 0;
        repeat (10) @(posedge clk);
        base = frames_done;
        @(posedge clk);
        #1 val_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            i_data = tab[i];
            if (i < 5) sb.push_back(to_dac(tab[i]));
            @(posedge clk); #1;
            if (o_ovf) ovf_cnt++;
        end
        val_in = 1'b0;
        checks++; if (o_level !== 3'd4) begin errors++; $display("FAIL burst_level: got %0d, expected 4", o_level); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (o_ovf) ovf_cnt++;
        end
        checks++; if (ovf_cnt !== 1) begin errors++; $display("FAIL burst_ovf: got %0d pulses, expected 1", ovf_cnt); end
        wait_frames(base + 5, 500);
    endtask

    task automatic test_push_on_pop();
        logic [15:0] tab [5] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
        int   base;
        logic pc;
        logic seen = 1'b0;
        repeat (10) @(posedge clk);
        base = frames_done;
        @(posedge clk);
        #1 val_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            i_data = tab[i];
            sb.push_back(to_dac(tab[i]));
            @(posedge clk); #1;
        end
        val_in = 1'b0;
        checks++; if (o_level !== 3'd4) begin errors++; $display("FAIL pop_fill_level: got %0d, expected 4", o_level); end
        pc = o_cs_n;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(posedge clk); #1;
            if (!pc && o_cs_n) seen = 1'b1;
            pc = o_cs_n;
        end
        checks++; if (!seen) begin errors++; $display("FAIL pop_cs_rise_timeout: seen %b, expected 1", seen); end
        repeat (2) @(posedge clk);
        #1 i_data = 16'h2468;
        val_in = 1'b1;
        sb.push_back(to_dac(16'h2468));
        @(posedge clk);
        #1 val_in = 1'b0;
        checks++; if (o_level !== 3'd4) begin errors++; $display("FAIL pop_push_level: got %0d, expected 4", o_level); end
        checks++; if (o_ovf !== 1'b0)   begin errors++; $display("FAIL pop_push_ovf: got %b, expected 0", o_ovf); end
        @(posedge clk); #1;
        checks++; if (o_cs_n !== 1'b0)  begin errors++; $display("FAIL pop_next_frame: cs_n %b, expected 0", o_cs_n); end
        wait_frames(base + 6, 600);
    endtask

    task automatic test_mid_reset();
        int   rises = 0;
        int   base;
        logic ps;
        repeat (10) @(posedge clk);
        send(16'h1234);
        send(16'h4321);
        ps = o_sclk;
        for (int n = 0; n < 200 && rises < 5; n++) begin
            @(posedge clk); #1;
            if (o_sclk && !ps) rises++;
            ps = o_sclk;
        end
        checks++; if (o_cs_n !== 1'b0)  begin errors++; $display("FAIL mid_in_frame: cs_n %b, expected 0", o_cs_n); end
        checks++; if (o_level !== 3'd1) begin errors++; $display("FAIL mid_level_pre: got %0d, expected 1", o_level); end
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checks++; if (o_cs_n !== 1'b1)  begin errors++; $display("FAIL mid_rst_cs_n: got %b, expected 1", o_cs_n); end
        checks++; if (o_sclk !== 1'b0)  begin errors++; $display("FAIL mid_rst_sclk: got %b, expected 0", o_sclk); end
        checks++; if (o_level !== 3'd0) begin errors++; $display("FAIL mid_rst_level: got %0d, expected 0", o_level); end
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        base = frames_done;
        send(16'h5AA5);
        wait_frames(base + 1, 200);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_raw();
        test_burst();
        test_push_on_pop();
        test_mid_reset();
        repeat (10) @(posedge clk);
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL sb_drain: %0d samples left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
